hazard_match_tracker: RTL and testbench

- Producer side of the hazard-unit interface for the 5-stage ARM pipeline.
- Carries per-instruction register/control tags (RA1, RA2, WA3, RegWrite, MemtoReg, PCSrc) from Decode through the Execute, Memory and Writeback stages.
- Generates the Match_* compare flags, the stage-qualified control bits and resetHit consumed by the hazard unit.
- Takes back StallD/FlushE/FlushD so its tag pipeline stays aligned with the datapath pipeline registers.

---
 rtl/hazard_match_tracker.sv | 166 ++++++++++++++++
 tb/tb_hazard_match_tracker.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_match_tracker.sv
// Decode->Writeback register/control tag pipeline that feeds the hazard unit.
// Define HAZ_PERF_CNT_EN to add load-stall and flush performance counters.
module hazard_match_tracker #(
    parameter int REG_W      = 4,
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ValidD,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             CondExE,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             FlushD,
    output logic             Match_1E_M,
    output logic             Match_1E_W,
    output logic             Match_2E_M,
    output logic             Match_2E_W,
    output logic             Match_12D_E,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             MemtoRegE,
    output logic             PCSrcE,
    output logic             PCSrcM,
    output logic             PCSrcW,
    output logic             resetHit
`ifdef HAZ_PERF_CNT_EN
   ,output logic [CNT_W-1:0] ldr_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] ra1;
        logic [REG_W-1:0] ra2;
        logic [REG_W-1:0] wa3;
        logic             regWrite;
        logic             memtoReg;
        logic             pcSrc;
    } exTag_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wa3;
        logic             regWrite;
        logic             memtoReg;
        logic             pcSrc;
    } tag_t;

    logic [HOLD_W-1:0] holdCnt;
    exTag_t tagE, tagENext;
    tag_t   tagM, tagMNext;
    tag_t   tagW, tagWNext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdCnt <= HOLD_W'(RESET_HOLD);
        end else if (holdCnt != '0) begin
            holdCnt <= holdCnt - HOLD_W'(1);
        end
    end

    assign resetHit = (holdCnt != '0);

    always_comb begin
        tagENext = '0;
        unique case (1'b1)
            (resetHit | FlushE | ~ValidD): tagENext = '0;
            default: begin
                tagENext.valid    = 1'b1;
                tagENext.ra1      = RA1D;
                tagENext.ra2      = RA2D;
                tagENext.wa3      = WA3D;
                tagENext.regWrite = RegWriteD;
                tagENext.memtoReg = MemtoRegD;
                tagENext.pcSrc    = PCSrcD;
            end
        endcase
    end

    // Condition failure in Execute squashes every side effect downstream.
    always_comb begin
        tagMNext = '0;
        if (!resetHit) begin
            tagMNext.valid    = tagE.valid;
            tagMNext.wa3      = tagE.wa3;
            tagMNext.regWrite = tagE.regWrite & CondExE;
            tagMNext.memtoReg = tagE.memtoReg & CondExE;
            tagMNext.pcSrc    = tagE.pcSrc & CondExE;
        end
    end

    always_comb begin
        tagWNext = '0;
        if (!resetHit) begin
            tagWNext = tagM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tagE <= '0;
            tagM <= '0;
            tagW <= '0;
        end else begin
            tagE <= tagENext;
            tagM <= tagMNext;
            tagW <= tagWNext;
        end
    end

    assign Match_1E_M = tagE.valid & tagM.valid & (tagE.ra1 == tagM.wa3);
    assign Match_1E_W = tagE.valid & tagW.valid & (tagE.ra1 == tagW.wa3);
    assign Match_2E_M = tagE.valid & tagM.valid & (tagE.ra2 == tagM.wa3);
    assign Match_2E_W = tagE.valid & tagW.valid & (tagE.ra2 == tagW.wa3);

    assign Match_12D_E = ValidD & tagE.valid &
                         ((RA1D == tagE.wa3) | (RA2D == tagE.wa3));

    assign RegWriteM = tagM.regWrite;
    assign RegWriteW = tagW.regWrite;
    assign MemtoRegE = tagE.memtoReg;
    assign PCSrcE    = tagE.pcSrc;
    assign PCSrcM    = tagM.pcSrc;
    assign PCSrcW    = tagW.pcSrc;

`ifdef HAZ_PERF_CNT_EN
    logic ldrStallEv;
    logic flushEv;

    assign ldrStallEv = StallD & FlushE & ~resetHit;
    assign flushEv    = FlushD & ~resetHit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ldr_stall_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            if (ldrStallEv && !(&ldr_stall_cnt)) begin
                ldr_stall_cnt <= ldr_stall_cnt + CNT_W'(1);
            end
            if (flushEv && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    logic unusedTagBits;
    assign unusedTagBits = tagW.memtoReg;
`else
    localparam int unusedCntW = CNT_W;

    logic unusedTagBits;
    assign unusedTagBits = ^{tagW.memtoReg, StallD, FlushD};
`endif

endmodule

// File: tb/tb_hazard_match_tracker.sv
// Randomised and directed bench for hazard_match_tracker.
// Reference model keeps an age-ordered history of admitted instructions.
`timescale 1ns/1ps
module tb_hazard_match_tracker;

    localparam int REG_W = 4;
    localparam int HOLD  = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic ValidD = 1'b0;
    logic [REG_W-1:0] RA1D = '0, RA2D = '0, WA3D = '0;
    logic RegWriteD = 1'b0, MemtoRegD = 1'b0, PCSrcD = 1'b0;
    logic CondExE = 1'b0, StallD = 1'b0, FlushE = 1'b0, FlushD = 1'b0;
    logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcE, PCSrcM, PCSrcW, resetHit;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] ldr_stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_match_tracker #(
        .REG_W(REG_W), .RESET_HOLD(HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ValidD(ValidD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .CondExE(CondExE), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_12D_E(Match_12D_E),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .resetHit(resetHit)
`ifdef HAZ_PERF_CNT_EN
       ,.ldr_stall_cnt(ldr_stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // One entry per instruction slot; cond is the flag seen while in Execute.
    typedef struct {
        bit       valid;
        bit [3:0] ra1, ra2, wa3;
        bit       rw, mr, pc, cond;
    } ent_t;

    ent_t hist[3];
    int holdLeft;
    int ldrModel, flushModel;

    function automatic void modelReset();
        for (int i = 0; i < 3; i++) hist[i] = '{default: 0};
        holdLeft = HOLD;
        ldrModel = 0;
        flushModel = 0;
    endfunction

    function automatic void modelEdge();
        ent_t n;
        if (!reset_n) return;
        if (holdLeft > 0) begin
            for (int i = 0; i < 3; i++) hist[i] = '{default: 0};
            holdLeft--;
            return;
        end
        if (StallD && FlushE && ldrModel < CMAX) ldrModel++;
        if (FlushD && flushModel < CMAX) flushModel++;
        hist[0].cond = CondExE;
        hist[2] = hist[1];
        hist[1] = hist[0];
        n = '{default: 0};
        if (ValidD && !FlushE) begin
            n.valid = 1; n.ra1 = RA1D; n.ra2 = RA2D; n.wa3 = WA3D;
            n.rw = RegWriteD; n.mr = MemtoRegD; n.pc = PCSrcD;
        end
        hist[0] = n;
    endfunction

    function automatic logic [11:0] expOut();
        ent_t e, m, w;
        bit rh;
        e = hist[0]; m = hist[1]; w = hist[2];
        rh = (holdLeft > 0) || !reset_n;
        return {e.valid && m.valid && (e.ra1 == m.wa3),
                e.valid && w.valid && (e.ra1 == w.wa3),
                e.valid && m.valid && (e.ra2 == m.wa3),
                e.valid && w.valid && (e.ra2 == w.wa3),
                ValidD && e.valid && (RA1D == e.wa3 || RA2D == e.wa3),
                m.rw && m.cond, w.rw && w.cond, e.mr, e.pc,
                m.pc && m.cond, w.pc && w.cond, rh};
    endfunction

    function automatic logic [11:0] outVec();
        return {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
                RegWriteM, RegWriteW, MemtoRegE, PCSrcE, PCSrcM, PCSrcW,
                resetHit};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic setD(bit v, bit [3:0] a1, bit [3:0] a2, bit [3:0] w,
                        bit rw, bit mr, bit pc);
        ValidD = v; RA1D = a1; RA2D = a2; WA3D = w;
        RegWriteD = rw; MemtoRegD = mr; PCSrcD = pc;
    endtask

    task automatic setC(bit c, bit st, bit fe, bit fd);
        CondExE = c; StallD = st; FlushE = fe; FlushD = fd;
    endtask

    task automatic randD();
        setD(($urandom % 4) != 0, 4'($urandom % 4), 4'($urandom % 4),
             4'($urandom % 4), 1'($urandom), 1'($urandom), 1'($urandom % 3 == 0));
    endtask

    task automatic randC();
        bit st;
        st = ($urandom % 5) == 0;
        setC(($urandom % 4) != 0, st, st | (($urandom % 6) == 0),
             ($urandom % 5) == 0);
    endtask

    task automatic test_reset();
        logic [11:0] obs, exp;
        #1;
        reset_n = 1'b0;
        modelReset();
        randD();
        setC(1, 0, 0, 1);
        #1;
        for (int i = 0; i < 3; i++) begin
            obs = outVec();
            checks++;
            if (obs !== 12'h001) begin
                errors++;
                $display("FAIL reset_low[%0d]: got %b want %b", i, obs, 12'h001);
            end
            tick();
            randD();
            #1;
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (resetHit !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: resetHit got %b want 1", resetHit);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            randD();
            setC(1'($urandom), 0, 0, 1'($urandom));
            #1;
            obs = outVec();
            exp = expOut();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold_vec[%0d]: got %b want %b", i, obs, exp);
            end
            checks++;
            if (resetHit !== (i < HOLD - 1)) begin
                errors++;
                $display("FAIL reset_hold_hit[%0d]: got %b want %b",
                         i, resetHit, (i < HOLD - 1));
            end
        end
    endtask

    task automatic test_forward();
        logic [11:0] obs, exp;
        setC(1, 0, 0, 0);
        setD(1, 1, 2, 3, 1, 0, 0);
        tick();
        setD(1, 3, 4, 6, 1, 0, 0);
        #1;
        checks++;
        if (Match_12D_E !== 1'b1) begin
            errors++;
            $display("FAIL fwd_d_e: got %b want 1", Match_12D_E);
        end
        tick();
        setD(1, 3, 9, 7, 0, 0, 0);
        #1;
        checks++;
        if ({Match_1E_M, RegWriteM} !== 2'b11) begin
            errors++;
            $display("FAIL fwd_e_m: got %b want 11", {Match_1E_M, RegWriteM});
        end
        tick();
        setD(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({Match_1E_W, RegWriteW} !== 2'b11) begin
            errors++;
            $display("FAIL fwd_e_w: got %b want 11", {Match_1E_W, RegWriteW});
        end
        obs = outVec();
        exp = expOut();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fwd_vec: got %b want %b", obs, exp);
        end
    endtask

    task automatic test_load_use();
        logic [11:0] obs, exp;
        setC(1, 0, 0, 0);
        setD(1, 0, 1, 5, 1, 1, 0);
        tick();
        setD(1, 7, 5, 8, 1, 0, 0);
        #1;
        checks++;
        if ({MemtoRegE, Match_12D_E} !== 2'b11) begin
            errors++;
            $display("FAIL ldr_detect: got %b want 11", {MemtoRegE, Match_12D_E});
        end
        setC(1, 1, 1, 0);
        tick();
        #1;
        checks++;
        if ({MemtoRegE, Match_12D_E} !== 2'b00) begin
            errors++;
            $display("FAIL ldr_bubble: got %b want 00", {MemtoRegE, Match_12D_E});
        end
        setC(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            obs = outVec();
            exp = expOut();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ldr_vec[%0d]: got %b want %b", i, obs, exp);
            end
            tick();
            setD(0, 0, 0, 0, 0, 0, 0);
            #1;
        end
    endtask

    task automatic test_branch();
        logic [2:0] got, want;
        for (int c = 0; c < 2; c++) begin
            setC(1, 0, 0, 0);
            setD(1, 0, 0, 0, 0, 0, 1);
            tick();
            setD(0, 0, 0, 0, 0, 0, 0);
            setC(1'(c), 0, 0, 0);
            for (int s = 0; s < 4; s++) begin
                #1;
                got = {PCSrcE, PCSrcM, PCSrcW};
                want = {s == 0, (s == 1) && (c == 1), (s == 2) && (c == 1)};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL branch[c%0d s%0d]: got %b want %b",
                             c, s, got, want);
                end
                tick();
                setC(1, 0, 0, 0);
            end
        end
    endtask

    task automatic test_bubble();
        logic [11:0] obs, exp;
        setC(1, 0, 0, 0);
        setD(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        setD(1, 0, 0, 0, 1, 0, 0);
        tick();
        setD(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) setD(1, 0, 0, 2, 0, 0, 0);
            #1;
            obs = outVec();
            exp = expOut();
            checks++;
            if (obs[11:7] !== 5'b0) begin
                errors++;
                $display("FAIL bubble_match[%0d]: got %b want 00000",
                         i, obs[11:7]);
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bubble_vec[%0d]: got %b want %b", i, obs, exp);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_random(int n);
        logic [11:0] obs, exp;
        for (int i = 0; i < n; i++) begin
            randD();
            randC();
            #1;
            obs = outVec();
            exp = expOut();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", i, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        logic [11:0] obs, exp;
        test_random(12);
        #3;
        reset_n = 1'b0;
        modelReset();
        #1;
        obs = outVec();
        checks++;
        if (obs !== 12'h001) begin
            errors++;
            $display("FAIL midreset: got %b want %b", obs, 12'h001);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            randD();
            randC();
            #1;
            obs = outVec();
            exp = expOut();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midreset_vec[%0d]: got %b want %b", i, obs, exp);
            end
            tick();
        end
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf();
        bit st;
        for (int i = 0; i < 20; i++) begin
            randD();
            st = 1'($urandom);
            setC(1, st, st, 1);
            tick();
            #1;
            checks++;
            if (flush_cnt !== CNT_W'(flushModel) ||
                ldr_stall_cnt !== CNT_W'(ldrModel)) begin
                errors++;
                $display("FAIL perf_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                         flush_cnt, ldr_stall_cnt, flushModel, ldrModel);
            end
        end
        checks++;
        if (flush_cnt !== 4'hF) begin
            errors++;
            $display("FAIL perf_sat: got %0d want 15", flush_cnt);
        end
        reset_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({flush_cnt, ldr_stall_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL perf_clear: got %0d/%0d want 0/0",
                     flush_cnt, ldr_stall_cnt);
        end
        tick();
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_bubble();
        test_random(300);
        test_midreset();
`ifdef HAZ_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
